msx_slot_initiator: RTL and testbench
=====================================

// Module: msx_slot_initiator
// PURPOSE
//  Host-side MSX slot bus cycle generator, the initiator counterpart of msx_slot.
//  - Accepts one request at a time on the internal valid/ready bus.
//  - Replays each request as a Z80-timed memory or I/O cycle on the slot pins, honouring /WAIT.
//  - Returns read data through bus_rdata/bus_rdata_en.
//  - Sits between an internal master (test host, CPU core) and a cartridge slot.
// PARAMETERS
//  CLK_DIV     24   clk cycles per slot T-state, even, >=8 (85.909 MHz / 24 = 3.58 MHz)
//  WAIT_LIMIT  255  max TW states added by /WAIT per cycle; further /WAIT is ignored
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   asynchronous active-low reset
//  bus_memreq      in   1   request is a memory cycle
//  bus_ioreq       in   1   request is an I/O cycle
//  bus_address     in   16  cycle address
//  bus_write       in   1   1=write, 0=read
//  bus_valid       in   1   request present
//  bus_ready       out  1   request accepted this clk (valid&ready)
//  bus_wdata       in   8   write data
//  bus_rdata       out  8   read data
//  bus_rdata_en    out  1   one-clk strobe, bus_rdata is valid
//  p_slot_clk      out  1   slot CPU clock: high when phase<CLK_DIV/2
//  p_slot_sltsl_n  out  1   slot select, memory cycles only
//  p_slot_mreq_n / p_slot_ioreq_n / p_slot_rd_n / p_slot_wr_n  out  1 each  strobes
//  p_slot_address  out  16  address pins
//  p_slot_dout     out  8   data to pins
//  p_slot_din      in   8   data from pins
//  p_slot_data_dir out  1   1=this block drives data pins
//  p_slot_wait_n   in   1   cartridge wait request (2-flop synchronised inside)
// BEHAVIOUR
//  - Reset: strobes and sltsl_n=1, p_slot_clk=1, address=0, dout=0, data_dir=0,
//    bus_ready=0, bus_rdata=0, bus_rdata_en=0, phase=0, FSM=IDLE.
//  - Phase counter 0..CLK_DIV-1 free-runs from reset. Wrap = T boundary (rise).
//    phase==CLK_DIV/2 = fall.
//  - bus_ready: 1-clk pulse in IDLE while bus_valid=1 and (memreq|ioreq).
//    Request fields are latched in the same clk.
//  - memreq wins when both are set. valid with neither set is ignored: no ready, no cycle.
//  - FSM: IDLE -> T1 at next T boundary -> T2 -> [TW...] -> T3 -> IDLE.
//  - I/O cycles always insert one automatic TW.
//  - T1 rise: address driven. Writes also set data_dir=1 and dout=wdata.
//  - Memory cycle:
//    - T1 fall: mreq_n=0, sltsl_n=0; read also rd_n=0.
//    - T2 fall (write): wr_n=0.
//  - I/O cycle: T2 rise, ioreq_n=0 plus rd_n or wr_n=0.
//  - WAIT: the synchronised wait_n is sampled at T2 fall and each TW fall.
//    Low adds a TW, until WAIT_LIMIT extra TWs; the cycle then proceeds.
//  - T3 rise (read): bus_rdata<=p_slot_din; bus_rdata_en=1 for exactly one clk.
//  - T3 fall: all strobes and sltsl_n=1.
//  - End of T3: data_dir=0, FSM=IDLE. Address holds its last value.
//  - Next request acceptance is possible in the clk after T3 ends.
//  - Latency from accept to the next T boundary: 1..CLK_DIV clks.
//    Cycle length: mem 3T, I/O 4T, plus waits.
//  - bus_valid changes during a cycle are ignored; latched fields are used.
//  - Reset mid-cycle: immediate return to reset values; no rdata_en.
// CONFIGURATION
//  MSX_SLOT_INITIATOR_M1WAIT_EN
//  - Defined: every memory cycle gets one automatic TW, as the MSX engine does.
//    Mem cycle = 4T before /WAIT.
//  - Undefined: no automatic memory wait; mem cycle = 3T.
//  - I/O behaviour is identical either way.
// TESTING
//  1 I/O write 0x98<-0x12, wait_n=1: ioreq_n/wr_n low T2 rise..T3 fall,
//    dout=0x12, data_dir=1, 4T total.
//  2 Mem read 0x4000, din=0xA5: sltsl_n/mreq_n/rd_n low T1 fall..T3 fall,
//    rdata_en 1 clk, rdata=0xA5, 3T (4T with macro).
//  3 I/O read 0x99, wait_n low 3 T-states: 3 extra TW, rdata sampled after wait release.
//  4 Mem write, wait_n stuck low, WAIT_LIMIT=4: exactly 4 extra TW, then cycle ends.
//  5 memreq=ioreq=1: memory cycle only. valid with neither set: no ready for 100 clks.
//  6 reset_n low during TW of an I/O read: strobes 1 and data_dir 0 immediately,
//    no rdata_en; next request runs normally.

Source files
------------

// File: rtl/msx_slot_initiator_if.sv
// Internal request/response bus of the MSX slot initiator.
// master: the host issuing cycles; slave: msx_slot_initiator.
interface msx_slot_initiator_if;
  logic        bus_memreq;
  logic        bus_ioreq;
  logic [15:0] bus_address;
  logic        bus_write;
  logic        bus_valid;
  logic        bus_ready;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;

  modport master (
    output bus_memreq, bus_ioreq, bus_address, bus_write, bus_valid, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_memreq, bus_ioreq, bus_address, bus_write, bus_valid, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/msx_slot_initiator.sv
// Host-side MSX slot bus cycle generator: replays one internal request at a
// time as a Z80-timed memory or I/O cycle on the slot pins, honouring /WAIT.
// Optional feature macro: MSX_SLOT_INITIATOR_M1WAIT_EN adds one automatic
// wait state to every memory cycle (MSX engine behaviour).
module msx_slot_initiator #(
  parameter int unsigned CLK_DIV    = 24,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  msx_slot_initiator_if.slave   bus,
  output logic                  p_slot_clk,
  output logic                  p_slot_sltsl_n,
  output logic                  p_slot_mreq_n,
  output logic                  p_slot_ioreq_n,
  output logic                  p_slot_rd_n,
  output logic                  p_slot_wr_n,
  output logic [15:0]           p_slot_address,
  output logic [7:0]            p_slot_dout,
  input  logic [7:0]            p_slot_din,
  output logic                  p_slot_data_dir,
  input  logic                  p_slot_wait_n
);

  localparam int unsigned PW   = $clog2(CLK_DIV);
  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned WCW  = $clog2(WAIT_LIMIT + 2);

`ifdef MSX_SLOT_INITIATOR_M1WAIT_EN
  localparam logic MEM_AUTO_TW = 1'b1;
`else
  localparam logic MEM_AUTO_TW = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PEND, S_T1, S_T2, S_TW, S_T3
  } state_t;

  state_t           state;
  logic [PW-1:0]    phase;
  logic             wait_meta;
  logic             wait_sync;
  logic             is_mem;
  logic             is_wr;
  logic [15:0]      lat_addr;
  logic [7:0]       lat_wdata;
  logic             tw_pend;
  logic [WCW-1:0]   wait_cnt;

  logic [PW-1:0]    phase_nxt_c;
  logic             rise_c;
  logic             fall_c;
  logic             auto_tw_c;
  logic             wait_more_c;

  // T-state event decode: rise on phase wrap, fall at mid-period
  always_comb begin
    rise_c      = (phase == PW'(CLK_DIV - 1));
    fall_c      = (phase == PW'(HALF - 1));
    phase_nxt_c = rise_c ? '0 : phase + PW'(1);
    auto_tw_c   = is_mem ? MEM_AUTO_TW : 1'b1;
    wait_more_c = !wait_sync && (wait_cnt < WCW'(WAIT_LIMIT));
  end

  // Two-flop synchroniser for the cartridge /WAIT input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_meta <= 1'b1;
      wait_sync <= 1'b1;
    end else begin
      wait_meta <= p_slot_wait_n;
      wait_sync <= wait_meta;
    end
  end

  // Phase counter, slot clock and bus-cycle state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      phase            <= '0;
      p_slot_clk       <= 1'b1;
      p_slot_sltsl_n   <= 1'b1;
      p_slot_mreq_n    <= 1'b1;
      p_slot_ioreq_n   <= 1'b1;
      p_slot_rd_n      <= 1'b1;
      p_slot_wr_n      <= 1'b1;
      p_slot_address   <= '0;
      p_slot_dout      <= '0;
      p_slot_data_dir  <= 1'b0;
      bus.bus_ready    <= 1'b0;
      bus.bus_rdata    <= '0;
      bus.bus_rdata_en <= 1'b0;
      is_mem           <= 1'b0;
      is_wr            <= 1'b0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      tw_pend          <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      phase            <= phase_nxt_c;
      p_slot_clk       <= (phase_nxt_c < PW'(HALF));
      bus.bus_ready    <= 1'b0;
      bus.bus_rdata_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.bus_valid && (bus.bus_memreq || bus.bus_ioreq)) begin
            bus.bus_ready <= 1'b1;
            is_mem        <= bus.bus_memreq;
            is_wr         <= bus.bus_write;
            lat_addr      <= bus.bus_address;
            lat_wdata     <= bus.bus_wdata;
            state         <= S_PEND;
          end
        end

        S_PEND: begin
          if (rise_c) begin
            state          <= S_T1;
            p_slot_address <= lat_addr;
            tw_pend        <= 1'b0;
            wait_cnt       <= '0;
            if (is_wr) begin
              p_slot_data_dir <= 1'b1;
              p_slot_dout     <= lat_wdata;
            end
          end
        end

        S_T1: begin
          if (fall_c && is_mem) begin
            p_slot_mreq_n  <= 1'b0;
            p_slot_sltsl_n <= 1'b0;
            if (!is_wr) p_slot_rd_n <= 1'b0;
          end
          if (rise_c) begin
            state <= S_T2;
            if (!is_mem) begin
              p_slot_ioreq_n <= 1'b0;
              if (is_wr) p_slot_wr_n <= 1'b0;
              else       p_slot_rd_n <= 1'b0;
            end
          end
        end

        S_T2, S_TW: begin
          if (fall_c) begin
            if (state == S_T2) begin
              if (is_mem && is_wr) p_slot_wr_n <= 1'b0;
              if (auto_tw_c) begin
                tw_pend <= 1'b1;
              end else begin
                tw_pend <= wait_more_c;
                if (wait_more_c) wait_cnt <= wait_cnt + WCW'(1);
              end
            end else begin
              tw_pend <= wait_more_c;
              if (wait_more_c) wait_cnt <= wait_cnt + WCW'(1);
            end
          end
          if (rise_c) begin
            if (tw_pend) begin
              state <= S_TW;
            end else begin
              state <= S_T3;
              if (!is_wr) begin
                bus.bus_rdata    <= p_slot_din;
                bus.bus_rdata_en <= 1'b1;
              end
            end
          end
        end

        S_T3: begin
          if (fall_c) begin
            p_slot_sltsl_n <= 1'b1;
            p_slot_mreq_n  <= 1'b1;
            p_slot_ioreq_n <= 1'b1;
            p_slot_rd_n    <= 1'b1;
            p_slot_wr_n    <= 1'b1;
          end
          if (rise_c) begin
            p_slot_data_dir <= 1'b0;
            state           <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msx_slot_initiator.sv
// Self-checking bench for msx_slot_initiator (CLK_DIV=8, WAIT_LIMIT=4).
module tb_msx_slot_initiator;

  localparam int unsigned CLK_DIV    = 8;
  localparam int unsigned WAIT_LIMIT = 4;
  localparam int          STUCK      = 255;
`ifdef MSX_SLOT_INITIATOR_M1WAIT_EN
  localparam int MEM_X = CLK_DIV;
`else
  localparam int MEM_X = 0;
`endif

  typedef struct {
    bit          memreq;
    bit          ioreq;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          wmode;
    bit          exp_ready;
    int          exp_len;
  } vec_t;

  typedef struct {
    bit          mem;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_slot_clk, p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n;
  logic        p_slot_rd_n, p_slot_wr_n, p_slot_data_dir;
  logic [15:0] p_slot_address;
  logic [7:0]  p_slot_dout;
  logic [7:0]  p_slot_din = 8'h00;
  logic        p_slot_wait_n = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  msx_slot_initiator_if bus ();

  msx_slot_initiator #(.CLK_DIV(CLK_DIV), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .p_slot_clk     (p_slot_clk),
    .p_slot_sltsl_n (p_slot_sltsl_n),
    .p_slot_mreq_n  (p_slot_mreq_n),
    .p_slot_ioreq_n (p_slot_ioreq_n),
    .p_slot_rd_n    (p_slot_rd_n),
    .p_slot_wr_n    (p_slot_wr_n),
    .p_slot_address (p_slot_address),
    .p_slot_dout    (p_slot_dout),
    .p_slot_din     (p_slot_din),
    .p_slot_data_dir(p_slot_data_dir),
    .p_slot_wait_n  (p_slot_wait_n)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle monitor: measures each strobe window and compares it against the scoreboard
  logic        in_cyc = 1'b0;
  int          m_len, m_en;
  bit          s_mem, s_io, s_rd, s_wr, s_sl;
  logic [15:0] m_addr;
  logic [7:0]  m_dout, m_rdata;
  logic        m_dir;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_cyc = 1'b0;
      sb.delete();
    end else if (!p_slot_mreq_n || !p_slot_ioreq_n) begin
      if (!in_cyc) begin
        in_cyc = 1'b1;
        m_len = 0; m_en = 0;
        s_mem = 0; s_io = 0; s_rd = 0; s_wr = 0; s_sl = 0;
        m_addr = p_slot_address; m_dout = p_slot_dout; m_dir = p_slot_data_dir;
        m_rdata = 8'h00;
      end
      m_len++;
      s_mem |= !p_slot_mreq_n;  s_io |= !p_slot_ioreq_n;
      s_rd  |= !p_slot_rd_n;    s_wr |= !p_slot_wr_n;  s_sl |= !p_slot_sltsl_n;
      if (bus.bus_rdata_en) begin m_en++; m_rdata = bus.bus_rdata; end
    end else begin
      if (bus.bus_rdata_en) check("stray_rdata_en", 1, 0);
      if (in_cyc) begin
        in_cyc = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_cycle", 1, 0);
        end else begin
          m_e = sb.pop_front();
          check("cyc_mreq",   32'(s_mem), 32'(m_e.mem));
          check("cyc_ioreq",  32'(s_io),  32'(!m_e.mem));
          check("cyc_sltsl",  32'(s_sl),  32'(m_e.mem));
          check("cyc_rd",     32'(s_rd),  32'(!m_e.wr));
          check("cyc_wr",     32'(s_wr),  32'(m_e.wr));
          check("cyc_addr",   32'(m_addr), 32'(m_e.addr));
          check("cyc_len",    32'(m_len), 32'(m_e.len));
          check("cyc_dir",    32'(m_dir), 32'(m_e.wr));
          check("cyc_rd_en",  32'(m_en),  m_e.wr ? 32'd0 : 32'd1);
          if (m_e.wr) check("cyc_dout",  32'(m_dout),  32'(m_e.data));
          else        check("cyc_rdata", 32'(m_rdata), 32'(m_e.data));
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 2000 && (sb.size() != 0 || in_cyc); i++) @(negedge clk);
    if (sb.size() != 0 || in_cyc) begin
      check("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic issue(input vec_t v, output bit got);
    int lim;
    @(posedge clk); #1;
    bus.bus_memreq  = v.memreq;
    bus.bus_ioreq   = v.ioreq;
    bus.bus_write   = v.wr;
    bus.bus_address = v.addr;
    bus.bus_wdata   = v.wdata;
    p_slot_din      = v.din;
    p_slot_wait_n   = (v.wmode != 0) ? 1'b0 : 1'b1;
    bus.bus_valid   = 1'b1;
    lim = v.exp_ready ? 4 * CLK_DIV : 100;
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (bus.bus_ready) got = 1;
    end
    @(posedge clk); #1;
    bus.bus_valid   = 1'b0;
    bus.bus_address = ~v.addr;
    bus.bus_wdata   = ~v.wdata;
    bus.bus_write   = ~v.wr;
  endtask

  // Wait until ioreq_n is low, then for n falling edges of the slot clock
  task automatic wait_falls(input int n);
    int  cnt;
    logic prev;
    for (int i = 0; i < 200 && p_slot_ioreq_n; i++) begin @(posedge clk); #1; end
    if (p_slot_ioreq_n) check("ioreq_timeout", 1, 0);
    cnt = 0;
    prev = p_slot_clk;
    for (int i = 0; i < 400 && cnt < n; i++) begin
      @(posedge clk); #1;
      if (prev && !p_slot_clk) cnt++;
      prev = p_slot_clk;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit   got;
    exp_t e;
    drain();
    repeat (CLK_DIV) @(posedge clk);
    if (v.exp_ready) begin
      e.mem  = v.memreq;
      e.wr   = v.wr;
      e.addr = v.addr;
      e.data = v.wr ? v.wdata : v.din;
      e.len  = v.exp_len;
      sb.push_back(e);
    end
    issue(v, got);
    check($sformatf("ready_v%0d", idx), 32'(got), 32'(v.exp_ready));
    if (v.wmode == STUCK) begin
      drain();
      p_slot_wait_n = 1'b1;
    end else if (v.wmode > 0) begin
      wait_falls(v.wmode + 1);
      p_slot_wait_n = 1'b1;
    end
    drain();
  endtask

  vec_t vt[8];
  vec_t vr;
  bit   got;
  logic en_seen;

  initial begin
    // memreq ioreq wr addr wdata din wmode exp_ready exp_len
    vt[0] = '{0, 1, 1, 16'h0098, 8'h12, 8'h00, 0,     1, 20};
    vt[1] = '{1, 0, 0, 16'h4000, 8'h00, 8'hA5, 0,     1, 16 + MEM_X};
    vt[2] = '{0, 1, 0, 16'h0099, 8'h00, 8'h3C, 3,     1, 44};
    vt[3] = '{1, 0, 1, 16'h8123, 8'h5A, 8'h00, STUCK, 1, 48 + MEM_X};
    vt[4] = '{1, 1, 0, 16'hC000, 8'h00, 8'h77, 0,     1, 16 + MEM_X};
    vt[5] = '{0, 0, 0, 16'h1234, 8'h00, 8'h00, 0,     0, 0};
    vt[6] = '{1, 0, 1, 16'h0001, 8'hFF, 8'h00, 0,     1, 16 + MEM_X};
    vt[7] = '{0, 1, 0, 16'h00FF, 8'h00, 8'h00, 0,     1, 20};
    vr    = '{0, 1, 0, 16'h0099, 8'h00, 8'h81, 0,     1, 20};

    bus.bus_memreq = 0; bus.bus_ioreq = 0; bus.bus_write = 0;
    bus.bus_address = '0; bus.bus_wdata = '0; bus.bus_valid = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_clk",      32'(p_slot_clk), 1);
    check("rst_sltsl",    32'(p_slot_sltsl_n), 1);
    check("rst_strobes",  32'({p_slot_mreq_n, p_slot_ioreq_n, p_slot_rd_n, p_slot_wr_n}), 32'hF);
    check("rst_addr",     32'(p_slot_address), 0);
    check("rst_dout",     32'(p_slot_dout), 0);
    check("rst_dir",      32'(p_slot_data_dir), 0);
    check("rst_ready",    32'(bus.bus_ready), 0);
    check("rst_rdata",    32'(bus.bus_rdata), 0);
    check("rst_rdata_en", 32'(bus.bus_rdata_en), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Reset during a TW of an I/O read
    repeat (CLK_DIV) @(posedge clk);
    vr.wmode = STUCK;
    issue(vr, got);
    check("ready_rst_req", 32'(got), 1);
    wait_falls(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_strobes", 32'({p_slot_ioreq_n, p_slot_rd_n, p_slot_sltsl_n}), 32'h7);
    check("midrst_dir",     32'(p_slot_data_dir), 0);
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      en_seen |= bus.bus_rdata_en;
    end
    check("midrst_no_en", 32'(en_seen), 0);
    p_slot_wait_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    vr.wmode = 0;
    run_vec(vr, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
